// File: rtl/program_loader.sv
// program_loader
// Boot-time instruction store for the 8-bit core. A program image arrives as
// a byte stream, is written into a DEPTH x DATA_W memory, and is followed by
// one checksum byte. The core is released from reset only when the image sum
// plus the checksum byte is 0 mod 256. The core fetches from the same memory
// through a combinational read port.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   load_start      one-cycle load request, load_len sampled with it
//   load_len[4:0]   image length in bytes (1..DEPTH)
//   in_valid/in_data/in_ready  image + checksum byte stream
//   fetch_addr      core PC
//   fetch_data      mem[fetch_addr], old word on read-during-write
//   cpu_reset       holds the core in reset (low only in RUN)
//   busy            loading or waiting for checksum
//   done            one-cycle pulse on successful verification
//   err             bad length or bad checksum
//   sum_out         running mod-256 sum of the current image
//
// state | meaning
// IDLE  | after reset, nothing loaded
// LOAD  | accepting image bytes into memory
// CKSUM | waiting for the checksum byte
// RUN   | image verified, core running
// ERR   | bad length or checksum, core held in reset
module program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [4:0]        load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] sum_out
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CKSUM = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [4:0]        count;
  logic [4:0]        len;
  logic [DATA_W-1:0] sum;
  logic              done_q;

  logic              accept;
  logic              start_ok;
  logic              len_ok;
  logic              last_byte;
  logic [DATA_W-1:0] sum_next;

  assign in_ready   = (state == ST_LOAD) || (state == ST_CKSUM);
  assign busy       = in_ready;
  assign cpu_reset  = (state != ST_RUN);
  assign err        = (state == ST_ERR);
  assign done       = done_q;
  assign sum_out    = sum;
  assign fetch_data = mem[fetch_addr];

  assign accept    = in_valid && in_ready;
  // Requests arriving mid-load are dropped so a stray pulse cannot corrupt an image.
  assign start_ok  = load_start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
  assign len_ok    = (load_len != 5'd0) && (load_len <= 5'(DEPTH));
  assign last_byte = ((count + 5'd1) == len);
  // In CKSUM this is image sum + checksum byte, which must wrap to zero.
  assign sum_next  = sum + in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      count  <= '0;
      len    <= '0;
      sum    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        if (len_ok) begin
          state  <= ST_LOAD;
          len    <= load_len;
          wr_ptr <= '0;
          count  <= '0;
          sum    <= '0;
        end else begin
          state <= ST_ERR;
        end
      end else if (accept) begin
        if (state == ST_LOAD) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + ADDR_W'(1);
          count       <= count + 5'd1;
          sum         <= sum_next;
          if (last_byte) begin
            state <= ST_CKSUM;
          end
        end else begin
          // Checksum byte: verified only, never stored, and not folded into sum_out.
          if (sum_next == '0) begin
            state  <= ST_RUN;
            done_q <= 1'b1;
          end else begin
            state <= ST_ERR;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic [4:0] load_len = 5'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] fetch_addr = 4'd0;
  logic [7:0] fetch_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sum_out;

  program_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
    .sum_out(sum_out)
  );

  always #5 clk = ~clk;

  // expected state classes
  localparam int IDL = 0;
  localparam int BSY = 1;  // LOAD or CKSUM
  localparam int RUN = 2;
  localparam int ERR = 3;

  typedef struct {
    logic        rst;
    logic        ls;
    logic [4:0]  len;
    logic        iv;
    logic [7:0]  id;
    logic [3:0]  fa;
    logic [20:0] exp;  // {in_ready, cpu_reset, busy, done, err, sum_out, fetch_data}
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nmis = 0;

  task automatic add(input logic rst, input logic ls, input logic [4:0] len,
                     input logic iv, input logic [7:0] id, input logic [3:0] fa,
                     input int st, input logic dn, input logic [7:0] sm,
                     input logic [7:0] fd);
    vec_t v;
    logic rdy, cr, bz, er;
    rdy = (st == BSY);
    bz  = (st == BSY);
    cr  = (st != RUN);
    er  = (st == ERR);
    v.rst = rst; v.ls = ls; v.len = len; v.iv = iv; v.id = id; v.fa = fa;
    v.exp = {rdy, cr, bz, dn, er, sm, fd};
    tbl.push_back(v);
  endtask

  function automatic logic [20:0] actual();
    return {in_ready, cpu_reset, busy, done, err, sum_out, fetch_data};
  endfunction

  initial begin
    int cyc;
    int ndone;
    logic [7:0] strm [3];
    logic [7:0] s;

    // ---- good load ----
    add(1,0,0,0,8'h00,0, IDL,0,8'h00,8'h00);
    add(0,1,3,0,8'h00,0, BSY,0,8'h00,8'h00);
    add(0,0,0,1,8'hA4,0, BSY,0,8'hA4,8'hA4);
    add(0,0,0,1,8'h5C,1, BSY,0,8'h00,8'h5C);
    add(0,0,0,1,8'h1B,1, BSY,0,8'h1B,8'h5C);
    add(0,0,0,1,8'hE5,1, RUN,1,8'h1B,8'h5C);
    add(0,0,0,0,8'h00,1, RUN,0,8'h1B,8'h5C);
    add(0,0,0,0,8'h00,2, RUN,0,8'h1B,8'h1B);
    // ---- bad checksum, then good reload ----
    add(0,1,3,0,8'h00,0, BSY,0,8'h00,8'hA4);
    add(0,0,0,1,8'hA4,0, BSY,0,8'hA4,8'hA4);
    add(0,0,0,1,8'h5C,0, BSY,0,8'h00,8'hA4);
    add(0,0,0,1,8'h1B,0, BSY,0,8'h1B,8'hA4);
    add(0,0,0,1,8'hE4,0, ERR,0,8'h1B,8'hA4);
    add(0,0,0,0,8'h00,0, ERR,0,8'h1B,8'hA4);
    add(0,1,3,0,8'h00,0, BSY,0,8'h00,8'hA4);
    add(0,0,0,1,8'hA4,0, BSY,0,8'hA4,8'hA4);
    add(0,0,0,1,8'h5C,0, BSY,0,8'h00,8'hA4);
    add(0,0,0,1,8'h1B,0, BSY,0,8'h1B,8'hA4);
    add(0,0,0,1,8'hE5,1, RUN,1,8'h1B,8'h5C);
    // ---- stalled stream, len 2: 11, 22, checksum CD ----
    add(0,1,2,0,8'h00,1, BSY,0,8'h00,8'h5C);
    add(0,0,0,1,8'h11,1, BSY,0,8'h11,8'h5C);
    add(0,0,0,0,8'h99,1, BSY,0,8'h11,8'h5C);
    add(0,0,0,0,8'h99,1, BSY,0,8'h11,8'h5C);
    add(0,0,0,1,8'h22,1, BSY,0,8'h33,8'h22);
    add(0,0,0,0,8'h77,1, BSY,0,8'h33,8'h22);
    add(0,0,0,1,8'hCD,1, RUN,1,8'h33,8'h22);
    add(0,0,0,1,8'h66,2, RUN,0,8'h33,8'h1B);
    add(0,0,0,0,8'h00,0, RUN,0,8'h33,8'h11);
    // ---- illegal lengths ----
    add(0,1,0,1,8'h55,0, ERR,0,8'h33,8'h11);
    add(0,0,0,1,8'h55,0, ERR,0,8'h33,8'h11);
    add(1,0,0,0,8'h00,0, IDL,0,8'h00,8'h00);
    add(0,1,17,1,8'h55,0, ERR,0,8'h00,8'h00);
    add(0,0,0,1,8'h55,0, ERR,0,8'h00,8'h00);
    // ---- full depth 00..0F, checksum 88 ----
    add(0,1,16,0,8'h00,0, BSY,0,8'h00,8'h00);
    for (int i = 0; i < 16; i++) begin
      add(0,0,0,1,8'(i),4'(i), BSY,0,8'((i*(i+1))/2),8'(i));
    end
    add(0,0,0,1,8'h88,15, RUN,1,8'h78,8'h0F);
    // ---- reload len 1: 7F, checksum 81 ----
    add(0,1,1,0,8'h00,0, BSY,0,8'h00,8'h00);
    add(0,0,0,1,8'h7F,0, BSY,0,8'h7F,8'h7F);
    add(0,0,0,1,8'h81,0, RUN,1,8'h7F,8'h7F);
    for (int i = 1; i < 16; i++) begin
      add(0,0,0,0,8'h00,4'(i), RUN,0,8'h7F,8'(i));
    end
    // ---- reset mid-load, start during LOAD ignored ----
    add(0,1,4,0,8'h00,0, BSY,0,8'h00,8'h7F);
    add(0,0,0,1,8'h10,0, BSY,0,8'h10,8'h10);
    add(0,0,0,1,8'h20,1, BSY,0,8'h30,8'h20);
    add(0,1,2,0,8'h00,1, BSY,0,8'h30,8'h20);
    add(1,1,2,1,8'h30,1, IDL,0,8'h00,8'h00);
    add(0,0,0,0,8'h00,0, IDL,0,8'h00,8'h00);
    add(0,0,0,0,8'h00,5, IDL,0,8'h00,8'h00);
    add(0,0,0,0,8'h00,15, IDL,0,8'h00,8'h00);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      reset = tbl[k].rst; load_start = tbl[k].ls; load_len = tbl[k].len;
      in_valid = tbl[k].iv; in_data = tbl[k].id; fetch_addr = tbl[k].fa;
      @(posedge clk);
      #1;
      nvec++;
      if (actual() !== tbl[k].exp) begin
        nmis++;
        $display("FAIL vec[%0d] {rdy,crst,busy,done,err,sum,fetch} got %h want %h",
                 k, actual(), tbl[k].exp);
      end
    end

    // ---- latency: len 2 image 01,02 + FD, expect release len+2 = 4 edges ----
    @(negedge clk);
    load_start = 1'b1; load_len = 5'd2; in_valid = 1'b0; fetch_addr = 4'd0;
    @(posedge clk);
    #1;
    cyc = 1;
    strm[0] = 8'h01; strm[1] = 8'h02; strm[2] = 8'hFD;
    while (cpu_reset && cyc < 20) begin
      @(negedge clk);
      load_start = 1'b0;
      in_valid = (cyc <= 3);
      s = (cyc <= 3) ? strm[cyc-1] : 8'h00;
      in_data = s;
      @(posedge clk);
      #1;
      cyc++;
    end
    nvec++;
    if (cyc != 4) begin
      nmis++;
      $display("FAIL latency edges got %0d want 4 (20 means timeout)", cyc);
    end
    // done must have been high exactly once in this window
    ndone = done ? 1 : 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    nvec++;
    if (ndone != 1) begin
      nmis++;
      $display("FAIL done_pulse count got %0d want 1", ndone);
    end
    nvec++;
    if (fetch_data !== 8'h01 || cpu_reset !== 1'b0) begin
      nmis++;
      $display("FAIL latency_final fetch/crst got %h/%b want 01/0", fetch_data, cpu_reset);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
